multi_edge_pulse: RTL and testbench
===================================

MULTI_EDGE_PULSE -- requirements
Module: multi_edge_pulse

Interface
REQ-001 SHALL have parameter CH, default 1: number of independent input channels (>=1).
REQ-002 SHALL have parameter SYNC, default 2: synchronizer stages per channel (>=2).
REQ-003 SHALL have parameter FILT, default 3: consecutive stable samples needed to accept a level change (>=1).
REQ-004 SHALL have parameter PW, default 1: output pulse width in clk cycles (>=1).
REQ-005 SHALL have parameter CNT_W, default 16: low-duration counter width (>=2).
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port i, input, CH: raw asynchronous line levels, idle high.
REQ-009 SHALL have port mode, input, 2: edge select, 00 falling, 01 rising, 10 both, 11 pulse output disabled.
REQ-010 SHALL have port q, output, CH: per-channel edge pulse.
REQ-011 SHALL have port low_len, output, CH*CNT_W: last measured low duration; channel n occupies bits [n*CNT_W +: CNT_W].
REQ-012 SHALL have port low_valid, output, CH: one-cycle strobe marking a new low_len value for the channel.

Function
REQ-013 Each channel SHALL be fully independent; mode SHALL be shared by all channels.
REQ-014 Each channel SHALL pass i through a SYNC-stage flip-flop chain; sync output = last stage.
REQ-015 Filtered level f SHALL toggle on the edge where sync output has differed from f for FILT consecutive samples, that sample included; any matching sample SHALL clear the stability count.
REQ-016 Raw pulses shorter than FILT cycles SHALL NOT change f, q, low_len or low_valid.
REQ-017 A qualifying f transition, per mode, SHALL drive q high from the next edge for exactly PW cycles.
REQ-018 Latency from a raw transition captured at edge E1 to q high SHALL be SYNC+FILT+1 edges; with defaults, 6 cycles.
REQ-019 A qualifying transition while q is already high SHALL restart the PW count (retrigger), with no low gap in q.
REQ-020 mode SHALL be sampled each cycle with no pipeline; a change affects only transitions detected after it.
REQ-021 mode=11 SHALL hold q low and cancel any pulse in progress; low-duration measurement SHALL continue.
REQ-022 On the edge where f falls, the low counter SHALL load 1; on each following edge with f=0, it SHALL increment, saturating at 2^CNT_W-1.
REQ-023 On the edge where f rises, low_len SHALL load the counter value and low_valid SHALL be high for exactly that one cycle.
REQ-024 low_len SHALL hold its value until the next rise of f; for any raw low of N>=FILT cycles, the measured value SHALL be min(N, 2^CNT_W-1).
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from i or mode to any output.

Reset
REQ-026 While rst=1, these SHALL be 0: q, low_valid, low_len, stability counters, low counters and PW counters.
REQ-027 While rst=1, all synchronizer stages and f SHALL be 1 (idle high), so releasing reset with i=1 produces no edge.
REQ-028 Asserting rst mid-pulse or mid-measurement SHALL abort it immediately, with no completion strobe after release.

Verification
REQ-029 Reset: assert rst with i toggling -> q=0, low_valid=0, low_len=0; release with i=1 -> outputs stay 0 for 20 cycles.
REQ-030 Defaults, mode=00: i falls and is held low for 45 cycles -> q high for 1 cycle, 6 edges after the fall. On the rise: no q, low_valid for 1 cycle, low_len=45.
REQ-031 Glitch, FILT=3: i low for 2 cycles -> no q, no low_valid, and low_len unchanged.
REQ-032 Retrigger, mode=10, PW=4: fall, then rise 3 cycles later -> q continuously high for 7 cycles, and low_len=3.
REQ-033 Saturation, CNT_W=4: i low for 40 cycles -> low_len=15 on the rise. Mode=11 during this run -> q stays 0 and low_valid still strobes.
REQ-034 CH=2, both channels: ch0 falls, ch1 falls 5 cycles later, and rst pulses mid-low. Required: q[0] and q[1] fire 5 cycles apart; after the reset, no low_valid on either channel until a full new low completes.

Source files
------------

// File: rtl/multi_edge_pulse.sv
// multi_edge_pulse: per-channel synchronizer, glitch filter, edge-pulse
// generator and low-duration meter. Lines idle high. One mode input is
// shared by every channel.
module multi_edge_pulse #(
  parameter int CH    = 1,
  parameter int SYNC  = 2,
  parameter int FILT  = 3,
  parameter int PW    = 1,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       i,
  input  logic [1:0]          mode,
  output logic [CH-1:0]       q,
  output logic [CH*CNT_W-1:0] low_len,
  output logic [CH-1:0]       low_valid
);

  typedef enum logic [1:0] {
    MODE_FALL = 2'b00,
    MODE_RISE = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  // Stability counter holds 0..FILT-1; pulse counter holds 0..PW-1.
  localparam int SW  = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int PWW = (PW > 1) ? $clog2(PW) : 1;

  mode_e mode_sel;
  assign mode_sel = mode_e'(mode);

  for (genvar n = 0; n < CH; n++) begin : g_ch
    logic [SYNC-1:0]  sync_r;
    logic             s;
    logic             f;
    logic [SW-1:0]    stab;
    logic             diff;
    logic             accept;
    logic             rise;
    logic             fall;
    logic             qual;
    logic             ev;
    logic             q_r;
    logic [PWW-1:0]   pw_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W-1:0] len_r;
    logic             valid_r;

    assign s = sync_r[SYNC-1];

    // Filter decode: the FILT-th consecutive differing sample flips f.
    always_comb begin
      diff   = (s != f);
      accept = diff && (stab == SW'(FILT - 1));
      rise   = accept && !f;
      fall   = accept && f;
      qual   = 1'b0;
      unique case (mode_sel)
        MODE_FALL: qual = fall;
        MODE_RISE: qual = rise;
        MODE_BOTH: qual = accept;
        MODE_OFF:  qual = 1'b0;
      endcase
    end

    // Synchronizer chain and stability filter; reset to the idle-high level
    // so leaving reset with the line high creates no edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_r <= '1;
        f      <= 1'b1;
        stab   <= '0;
      end else begin
        // NOTE: non-blocking so every stage samples the previous cycle's value.
        sync_r <= {sync_r[SYNC-2:0], i[n]};
        if (!diff) begin
          stab <= '0;
        end else if (accept) begin
          stab <= '0;
          f    <= ~f;
        end else begin
          stab <= stab + SW'(1);
        end
      end
    end

    // Pulse generator: the detected edge is registered in ev so q rises one
    // edge after f changes; a new edge reloads the count (retrigger).
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ev     <= 1'b0;
        q_r    <= 1'b0;
        pw_cnt <= '0;
      end else begin
        ev <= qual;
        if (mode_sel == MODE_OFF) begin
          q_r    <= 1'b0;
          pw_cnt <= '0;
        end else if (ev) begin
          q_r    <= 1'b1;
          pw_cnt <= PWW'(PW - 1);
        end else if (pw_cnt != '0) begin
          pw_cnt <= pw_cnt - PWW'(1);
        end else begin
          q_r <= 1'b0;
        end
      end
    end

    // Low-duration meter: starts at 1 on the fall of f, saturates, and is
    // published with a one-cycle strobe on the rise of f.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        low_cnt <= '0;
        len_r   <= '0;
        valid_r <= 1'b0;
      end else begin
        valid_r <= rise;
        if (fall) begin
          low_cnt <= CNT_W'(1);
        end else if (rise) begin
          len_r <= low_cnt;
        end else if (!f && (low_cnt != '1)) begin
          low_cnt <= low_cnt + CNT_W'(1);
        end
      end
    end

    assign q[n]                     = q_r;
    assign low_valid[n]             = valid_r;
    assign low_len[n*CNT_W +: CNT_W] = len_r;
  end

endmodule

// File: tb/tb_multi_edge_pulse.sv
// tb_multi_edge_pulse: directed checks on two instances, one with default
// parameters and one with CH=2, PW=4, CNT_W=4.
module tb_multi_edge_pulse;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] a_i, a_q, a_lv;
  logic [1:0] a_mode;
  logic [15:0] a_len;
  logic [1:0] b_i, b_q, b_lv;
  logic [1:0] b_mode;
  logic [7:0] b_len;

  always #5 clk = ~clk;

  multi_edge_pulse u_a (
    .clk(clk), .rst(rst), .i(a_i), .mode(a_mode),
    .q(a_q), .low_len(a_len), .low_valid(a_lv)
  );

  multi_edge_pulse #(.CH(2), .PW(4), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .i(b_i), .mode(b_mode),
    .q(b_q), .low_len(b_len), .low_valid(b_lv)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a_qcnt, a_lvcnt, a_first;
  int b_qcnt [2];
  int b_lvcnt[2];
  int b_first[2];
  int b_last0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic clear_counts();
    a_qcnt = 0; a_lvcnt = 0; a_first = -1;
    b_last0 = -1;
    for (int c = 0; c < 2; c++) begin
      b_qcnt[c] = 0; b_lvcnt[c] = 0; b_first[c] = -1;
    end
  endtask

  // Advance one clock and sample all outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (a_q[0] === 1'b1) begin
      a_qcnt++;
      if (a_first < 0) a_first = cyc;
    end
    if (a_lv[0] === 1'b1) a_lvcnt++;
    for (int c = 0; c < 2; c++) begin
      if (b_q[c] === 1'b1) begin
        b_qcnt[c]++;
        if (b_first[c] < 0) b_first[c] = cyc;
        if (c == 0) b_last0 = cyc;
      end
      if (b_lv[c] === 1'b1) b_lvcnt[c]++;
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    int         n;
    int         exp_q;
    int         exp_v;
    int         exp_len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int start;
    // {mode, raw low cycles, q cycles, low_valid strobes, low_len after}
    vecs[0] = '{2'b00, 45, 1, 1, 45};
    vecs[1] = '{2'b00,  2, 0, 0, 45};  // glitch below FILT: nothing changes
    vecs[2] = '{2'b01, 10, 1, 1, 10};
    vecs[3] = '{2'b10,  5, 2, 1,  5};
    vecs[4] = '{2'b11,  7, 0, 1,  7};  // output disabled, meter still runs
    vecs[5] = '{2'b00,  3, 1, 1,  3};  // exactly FILT cycles low
    vecs[6] = '{2'b10,  1, 0, 0,  3};

    // Reset with toggling inputs
    rst = 1'b1; a_i = 1'b0; b_i = 2'b00; a_mode = 2'b00; b_mode = 2'b00;
    clear_counts();
    for (int k = 0; k < 6; k++) begin
      a_i = ~a_i; b_i = ~b_i;
      tick();
    end
    check("rst_q", {a_q, b_q}, 3'b000);
    check("rst_low_valid", {a_lv, b_lv}, 3'b000);
    check("rst_low_len", {a_len, b_len}, 24'd0);
    a_i = 1'b1; b_i = 2'b11;
    tick();
    rst = 1'b0;
    clear_counts();
    repeat (20) tick();
    check("post_rst_quiet", a_qcnt + a_lvcnt + b_qcnt[0] + b_qcnt[1] + b_lvcnt[0] + b_lvcnt[1], 0);
    check("post_rst_len", {a_len, b_len}, 24'd0);

    // Latency: raw fall captured at the first edge, q high after the sixth
    a_mode = 2'b00;
    clear_counts();
    start = cyc;
    a_i = 1'b0;
    repeat (45) tick();
    check("latency_edges", a_first - start, 6);
    a_i = 1'b1;
    repeat (20) tick();
    check("latency_q_cycles", a_qcnt, 1);

    // Table-driven vectors on the default instance
    for (int v = 0; v < 7; v++) begin
      a_mode = vecs[v].mode;
      clear_counts();
      a_i = 1'b0;
      repeat (vecs[v].n) tick();
      a_i = 1'b1;
      repeat (20) tick();
      check($sformatf("vec%0d_q_cycles", v), a_qcnt, vecs[v].exp_q);
      check($sformatf("vec%0d_low_valid", v), a_lvcnt, vecs[v].exp_v);
      check($sformatf("vec%0d_low_len", v), a_len, vecs[v].exp_len);
    end

    // Retrigger: both edges 3 cycles apart, PW=4 -> 7 contiguous high cycles
    b_mode = 2'b10;
    clear_counts();
    b_i[0] = 1'b0;
    repeat (3) tick();
    b_i[0] = 1'b1;
    repeat (20) tick();
    check("retrig_q_cycles", b_qcnt[0], 7);
    check("retrig_q_span", b_last0 - b_first[0] + 1, 7);
    check("retrig_low_len", b_len[3:0], 3);

    // Saturation with output disabled: 40 low cycles into a 4-bit meter
    b_mode = 2'b11;
    clear_counts();
    b_i[1] = 1'b0;
    repeat (40) tick();
    b_i[1] = 1'b1;
    repeat (20) tick();
    check("sat_q_cycles", b_qcnt[1], 0);
    check("sat_low_valid", b_lvcnt[1], 1);
    check("sat_low_len", b_len[7:4], 15);

    // Two channels 5 cycles apart, then reset while q[1] is mid-pulse
    b_mode = 2'b00;
    clear_counts();
    b_i[0] = 1'b0;
    repeat (5) tick();
    b_i[1] = 1'b0;
    for (int k = 0; k < 30 && b_first[1] < 0; k++) tick();
    check("ch_spacing", b_first[1] - b_first[0], 5);
    rst = 1'b1;
    #1;
    check("mid_rst_q", b_q, 2'b00);
    check("mid_rst_low_len", b_len, 8'd0);
    b_i = 2'b11;
    tick();
    rst = 1'b0;
    clear_counts();
    repeat (20) tick();
    check("abort_no_valid", b_lvcnt[0] + b_lvcnt[1], 0);
    check("abort_no_q", b_qcnt[0] + b_qcnt[1], 0);
    // A complete new low is measured normally
    clear_counts();
    b_i = 2'b00;
    repeat (8) tick();
    b_i = 2'b11;
    repeat (20) tick();
    check("new_low_valid", {b_lvcnt[1][7:0], b_lvcnt[0][7:0]}, {8'd1, 8'd1});
    check("new_low_len", b_len, {4'd8, 4'd8});
    check("new_low_q", {b_qcnt[1][7:0], b_qcnt[0][7:0]}, {8'd4, 8'd4});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
